fp32_align_iter: RTL and testbench
==================================

# fp32_align_iter

Iterative pre-add alignment stage for the FP32 adder path of the matrix-multiplier datapath. It accepts two IEEE-754 single-precision operands through a valid/ready handshake, unpacks them, orders them by magnitude, and right-shifts the smaller mantissa one bit per clock until the exponents match. It presents 24-bit aligned mantissas, the common exponent and a sticky bit to the mantissa adder. The adder's 25-bit sum and `exp_base` then feed the post-add normalization stage.

## Interface
- `MAX_SHIFT`, 24: exponent difference at or above which the small mantissa is flushed in one step.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a`, `b` are valid.
- `in_ready`  out  1  block can accept operands; high exactly when state is IDLE.
- `a`, `b`  in  32  FP32 operands.
- `out_valid`  out  1  aligned result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `man_big`  out  24  mantissa of the larger-magnitude operand, hidden bit at [23].
- `man_small`  out  24  right-shifted mantissa of the smaller operand.
- `exp_base`  out  8  exponent of the larger operand.
- `sign_big`, `sign_small`  out  1  signs of the larger and smaller operands.
- `swap`  out  1  1 when `b` is the larger operand.
- `sticky`  out  1  OR of all bits shifted out of `man_small`.
- `special`  out  1  either operand has exponent 0xFF (Inf/NaN).

## Operation
- **Unpack.**
  - Exponent 0 gives mantissa 0 (denormals are flushed to zero).
  - Otherwise mantissa = {1, frac[22:0]}.
- **Order.** `a` is the larger operand if exp_a > exp_b, or if exp_a == exp_b and frac_a >= frac_b. In that case `swap` = 0; otherwise `swap` = 1 and the roles exchange.
- **Difference.** diff = exp_big − exp_small, an 8-bit unsigned value that is never negative after ordering.
- **States:** IDLE, ALIGN, DONE.
- **IDLE.** When `in_valid` is high, the block captures the unpacked and ordered fields, clears `sticky`, and loads count = diff. It then goes to:
  - DONE if diff == 0 or `special` (no shift is performed);
  - DONE if diff >= `MAX_SHIFT`, with `sticky` = OR(man_small) and `man_small` = 0;
  - ALIGN otherwise.
- **ALIGN.** Each cycle:
  - `man_small` <= `man_small` >> 1;
  - `sticky` <= `sticky` | `man_small`[0];
  - count <= count − 1;
  - the state moves to DONE when count == 1 (the last shift is performed in that same cycle).
- **DONE.** `out_valid` = 1 and all outputs are held stable. When `out_ready` is high, the block returns to IDLE. There is no overlap: a new operand is accepted no earlier than the cycle after the handshake.
- **Reset.** `rst_n` low forces IDLE from any state, including mid-ALIGN, and the partial operation is discarded.
  - All registered outputs reset to 0: `out_valid`, `man_big`, `man_small`, `exp_base`, `sign_big`, `sign_small`, `swap`, `sticky`, `special`.
  - `in_ready` = 1, since the state is IDLE.

## Timing
- Edge k is the edge on which the input handshake (`in_valid` & `in_ready`) completes.
- **Direct cases** (diff 0, diff >= 24, special): `out_valid` is high after edge k, giving 1 cycle of latency.
- **Shift cases** (1 <= diff <= 23): the block is in ALIGN after edge k and `out_valid` rises after edge k+diff, giving diff+1 cycles of latency. The maximum is 24 cycles.
- The output handshake completes on an edge where `out_valid` & `out_ready` are both high. `out_valid` is low after that edge and `in_ready` is high.
- Backpressure: `out_valid` and all data outputs hold unchanged while `out_ready` is low. `in_valid` is ignored outside IDLE.
- `in_ready` is combinational from state only and never depends on `in_valid`.
- Throughput is at most one operation per (latency + 1) cycles.

## Test plan
1. **Equal operands, diff 0.** a = b = 0x3F800000 with `out_ready` = 1.
   - `out_valid` 1 cycle after accept.
   - `man_big` = `man_small` = 0x800000, `exp_base` = 0x7F, `swap` = 0, `sticky` = 0.
2. **Swap, diff 1.** a = 0x3F800000 (1.0), b = 0x40400000 (3.0).
   - `swap` = 1, `man_big` = 0xC00000, `exp_base` = 0x80.
   - `man_small` = 0x400000, `sticky` = 0, latency 2.
3. **Maximum iterative shift, diff 23.** a = 0x4B000000, b = 0x3F800001.
   - 23 ALIGN cycles, latency 24.
   - `man_small` = 0x000001, `sticky` = 1, `exp_base` = 0x96.
4. **Flush, diff 24, and zero operand.**
   - a = 0x4B800000, b = 0x3F800000: latency 1, `man_small` = 0, `sticky` = 1.
   - a = 0x3F800000, b = 0x00000000: `man_small` = 0, `sticky` = 0, `swap` = 0.
5. **Backpressure.** Run scenario 2, hold `out_ready` = 0 for 5 cycles while presenting a new `in_valid` with different data.
   - Outputs stay stable and `in_ready` = 0 throughout.
   - After `out_ready` = 1, the block returns to IDLE and accepts the new operands next cycle.
6. **Reset mid-ALIGN.** Start scenario 3 and pull `rst_n` low after 10 ALIGN cycles.
   - `out_valid` and all outputs go to 0 asynchronously; state is IDLE and `in_ready` = 1.
   - After release, scenario 1 completes correctly.

Source files
------------

// File: rtl/fp32_align_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_align_iter
//  Purpose  : Iterative FP32 pre-add alignment. Unpacks two operands, orders
//             them by magnitude and shifts the smaller mantissa right one bit
//             per clock until both share the larger exponent.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_align_iter #(
    parameter int unsigned MAX_SHIFT = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [23:0] man_big_o,
    output logic [23:0] man_small_o,
    output logic [7:0]  exp_base_o,
    output logic        sign_big_o,
    output logic        sign_small_o,
    output logic        swap_o,
    output logic        sticky_o,
    output logic        special_o
);

    localparam logic [7:0] C_MAX_SHIFT = 8'(MAX_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [23:0] man_big_q, man_big_d;
    logic [23:0] man_small_q, man_small_d;
    logic [7:0]  exp_base_q, exp_base_d;
    logic        sign_big_q, sign_big_d;
    logic        sign_small_q, sign_small_d;
    logic        swap_q, swap_d;
    logic        sticky_q, sticky_d;
    logic        special_q, special_d;

    logic [7:0]  w_exp_a, w_exp_b;
    logic [23:0] w_man_a, w_man_b;
    logic        w_a_big;
    logic [7:0]  w_exp_big, w_exp_small;
    logic [23:0] w_man_big, w_man_small;
    logic [7:0]  w_diff;
    logic        w_special;

    // Unpack both operands (denormals flush to zero) and order by magnitude.
    always_comb begin
        w_exp_a     = a_i[30:23];
        w_exp_b     = b_i[30:23];
        w_man_a     = (w_exp_a == 8'd0) ? 24'd0 : {1'b1, a_i[22:0]};
        w_man_b     = (w_exp_b == 8'd0) ? 24'd0 : {1'b1, b_i[22:0]};
        w_a_big     = (w_exp_a > w_exp_b) ||
                      ((w_exp_a == w_exp_b) && (a_i[22:0] >= b_i[22:0]));
        w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
        w_exp_small = w_a_big ? w_exp_b : w_exp_a;
        w_man_big   = w_a_big ? w_man_a : w_man_b;
        w_man_small = w_a_big ? w_man_b : w_man_a;
        w_diff      = w_exp_big - w_exp_small;
        w_special   = (&w_exp_a) | (&w_exp_b);
    end

    // Next-state and datapath update for the IDLE -> ALIGN -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        man_big_d    = man_big_q;
        man_small_d  = man_small_q;
        exp_base_d   = exp_base_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        swap_d       = swap_q;
        sticky_d     = sticky_q;
        special_d    = special_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    man_big_d    = w_man_big;
                    man_small_d  = w_man_small;
                    exp_base_d   = w_exp_big;
                    sign_big_d   = w_a_big ? a_i[31] : b_i[31];
                    sign_small_d = w_a_big ? b_i[31] : a_i[31];
                    swap_d       = ~w_a_big;
                    special_d    = w_special;
                    sticky_d     = 1'b0;
                    count_d      = w_diff;
                    if (w_special || (w_diff == 8'd0)) begin
                        state_d = S_DONE;
                    end else if (w_diff >= C_MAX_SHIFT) begin
                        // Everything would be shifted out: flush in one step.
                        man_small_d = 24'd0;
                        sticky_d    = |w_man_small;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                man_small_d = man_small_q >> 1;
                sticky_d    = sticky_q | man_small_q[0];
                count_d     = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= 8'd0;
            man_big_q    <= 24'd0;
            man_small_q  <= 24'd0;
            exp_base_q   <= 8'd0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swap_q       <= 1'b0;
            sticky_q     <= 1'b0;
            special_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            man_big_q    <= man_big_d;
            man_small_q  <= man_small_d;
            exp_base_q   <= exp_base_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            swap_q       <= swap_d;
            sticky_q     <= sticky_d;
            special_q    <= special_d;
        end
    end

    assign in_ready_o   = (state_q == S_IDLE);
    assign out_valid_o  = (state_q == S_DONE);
    assign man_big_o    = man_big_q;
    assign man_small_o  = man_small_q;
    assign exp_base_o   = exp_base_q;
    assign sign_big_o   = sign_big_q;
    assign sign_small_o = sign_small_q;
    assign swap_o       = swap_q;
    assign sticky_o     = sticky_q;
    assign special_o    = special_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_align_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_align_iter
//  Purpose  : Self-checking bench for fp32_align_iter: directed scenarios with
//             literal expectations plus randomized traffic against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_align_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] man_big, man_small;
    logic [7:0]  exp_base;
    logic        sign_big, sign_small, swap, sticky, special;

    int n_cmp = 0;
    int n_err = 0;

    fp32_align_iter #(.MAX_SHIFT(24)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .a_i          (a),
        .b_i          (b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .man_big_o    (man_big),
        .man_small_o  (man_small),
        .exp_base_o   (exp_base),
        .sign_big_o   (sign_big),
        .sign_small_o (sign_small),
        .swap_o       (swap),
        .sticky_o     (sticky),
        .special_o    (special)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] mb;
        logic [23:0] ms;
        logic [7:0]  e;
        logic        sb;
        logic        ss;
        logic        sw;
        logic        st;
        logic        sp;
        int          lat;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: what the aligned operands must be, using plain arithmetic.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t   r;
        int     ex, ey, eb, es, d;
        longint mx, my, big, sml, div;
        bit     a_big;
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        mx    = (ex == 0) ? 0 : longint'(x[22:0]) + 64'h800000;
        my    = (ey == 0) ? 0 : longint'(y[22:0]) + 64'h800000;
        a_big = (ex > ey) || (ex == ey && x[22:0] >= y[22:0]);
        big   = a_big ? mx : my;
        sml   = a_big ? my : mx;
        eb    = a_big ? ex : ey;
        es    = a_big ? ey : ex;
        d     = eb - es;
        r.sw  = !a_big;
        r.sb  = a_big ? x[31] : y[31];
        r.ss  = a_big ? y[31] : x[31];
        r.e   = 8'(eb);
        r.mb  = 24'(big);
        r.sp  = (ex == 255) || (ey == 255);
        if (r.sp || d == 0) begin
            r.ms = 24'(sml); r.st = 1'b0; r.lat = 1;
        end else if (d >= 24) begin
            r.ms = 24'd0; r.st = (sml != 0); r.lat = 1;
        end else begin
            div  = longint'(1) << d;
            r.ms = 24'(sml / div);
            r.st = (sml % div) != 0;
            r.lat = d + 1;
        end
        return r;
    endfunction

    // Compare process: on every falling edge check outputs against the model.
    exp_t exp_q;
    bit   have_exp = 1'b0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            have_exp = 1'b0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!have_exp));
            if (!have_exp) begin
                chk("out_valid_idle", 32'(out_valid), 32'd0);
            end else if (cyc - acc_cyc < exp_q.lat) begin
                chk("out_valid_early", 32'(out_valid), 32'd0);
            end else begin
                chk("out_valid", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    chk("man_big", 32'(man_big), 32'(exp_q.mb));
                    chk("man_small", 32'(man_small), 32'(exp_q.ms));
                    chk("exp_base", 32'(exp_base), 32'(exp_q.e));
                    chk("sign_big", 32'(sign_big), 32'(exp_q.sb));
                    chk("sign_small", 32'(sign_small), 32'(exp_q.ss));
                    chk("swap", 32'(swap), 32'(exp_q.sw));
                    chk("sticky", 32'(sticky), 32'(exp_q.st));
                    chk("special", 32'(special), 32'(exp_q.sp));
                end
            end
            if (have_exp && out_valid && out_ready && (cyc - acc_cyc >= exp_q.lat))
                have_exp = 1'b0;
            if (in_valid && in_ready) begin
                exp_q    = model(a, b);
                have_exp = 1'b1;
                acc_cyc  = cyc;
            end
        end
    end

    // Present operands once the block is idle; returns just after the accept edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("send_in_ready_timeout", 32'(in_ready), 32'd1);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] y, input int lat_r,
                       input logic [23:0] mb, input logic [23:0] ms, input logic [7:0] e,
                       input logic sw, input logic st, input logic sp);
        int lat;
        send(x, y);
        wait_valid(lat);
        chk("lit_latency", 32'(lat), 32'(lat_r));
        chk("lit_man_big", 32'(man_big), 32'(mb));
        chk("lit_man_small", 32'(man_small), 32'(ms));
        chk("lit_exp_base", 32'(exp_base), 32'(e));
        chk("lit_swap", 32'(swap), 32'(sw));
        chk("lit_sticky", 32'(sticky), 32'(st));
        chk("lit_special", 32'(special), 32'(sp));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_pair_b(input logic [31:0] x);
        int ex, ey;
        logic [31:0] y;
        ex = int'(x[30:23]);
        y  = $urandom;
        case ($urandom_range(0, 7))
            0:       ey = ex;
            1:       ey = 255;
            2:       ey = 0;
            default: ey = ex - int'($urandom_range(0, 30));
        endcase
        if (ey < 0) ey = 0;
        if ($urandom_range(0, 7) == 0) y[22:0] = x[22:0];
        y[30:23] = 8'(ey);
        return y;
    endfunction

    initial begin
        exp_t m;
        int   lat;
        logic [31:0] x, y, t;
        logic [23:0] ms_hold;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;

        // Model pins against hand-computed values.
        m = model(32'h3F800000, 32'h40400000);
        chk("model_s2_swap", 32'(m.sw), 32'd1);
        chk("model_s2_mb", 32'(m.mb), 32'hC00000);
        chk("model_s2_ms", 32'(m.ms), 32'h400000);
        chk("model_s2_lat", 32'(m.lat), 32'd2);
        m = model(32'h4B000000, 32'h3F800001);
        chk("model_s3_ms", 32'(m.ms), 32'h000001);
        chk("model_s3_st", 32'(m.st), 32'd1);
        chk("model_s3_lat", 32'(m.lat), 32'd24);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_man_big", 32'(man_big), 32'd0);
        chk("reset_exp_base", 32'(exp_base), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios with literal expectations.
        run(32'h3F800000, 32'h3F800000, 1,  24'h800000, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0);
        run(32'h3F800000, 32'h40400000, 2,  24'hC00000, 24'h400000, 8'h80, 1'b1, 1'b0, 1'b0);
        run(32'h4B000000, 32'h3F800001, 24, 24'h800000, 24'h000001, 8'h96, 1'b0, 1'b1, 1'b0);
        run(32'h4B800000, 32'h3F800000, 1,  24'h800000, 24'h000000, 8'h97, 1'b0, 1'b1, 1'b0);
        run(32'h3F800000, 32'h00000000, 1,  24'h800000, 24'h000000, 8'h7F, 1'b0, 1'b0, 1'b0);
        run(32'h7F800000, 32'h3F800000, 1,  24'h800000, 24'h800000, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Backpressure: hold the result while new operands wait.
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40400000);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd2);
        ms_hold = man_small;
        a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_man_small", 32'(man_small), 32'(ms_hold));
            chk("bp_man_big", 32'(man_big), 32'hC00000);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_out_valid", 32'(out_valid), 32'd1);
        chk("bp_next_man_small", 32'(man_small), 32'h800000);
        chk("bp_next_exp_base", 32'(exp_base), 32'h7F);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a long alignment.
        send(32'h4B000000, 32'h3F800001);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_man_big", 32'(man_big), 32'd0);
        chk("arst_man_small", 32'(man_small), 32'd0);
        chk("arst_exp_base", 32'(exp_base), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(32'h3F800000, 32'h3F800000, 1, 24'h800000, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random backpressure; the compare process checks it.
        for (int i = 0; i < 4000; i++) begin
            x = $urandom;
            y = rnd_pair_b(x);
            if ($urandom_range(0, 1) == 1) begin t = x; x = y; y = t; end
            a = x; b = y;
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
